// File: rtl/lsu_exec_if.sv
// AXI4-Lite style read/write channel bundle between the load/store unit and its memory port.
// Only the signals the LSU drives or consumes are carried; awid/arid are constant ties.
interface lsu_exec_if #(
    parameter int ADDR_W = 22,
    parameter int ID_W   = 4
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ID_W-1:0]   awid;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arid, awid,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arid, awid,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/lsu_exec.sv
// Single-outstanding load/store unit: one request strobe becomes one AXI read or write.
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses without bus traffic.
module lsu_exec #(
    parameter int ADDR_W = 22,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    output logic              done,
    output logic [31:0]       data,
    output logic              err,
    lsu_exec_if.master        bus
);

    // state | meaning
    // IDLE  | waiting for enable; only state that accepts a request
    // RD_A  | read address offered (arvalid)
    // RD_D  | waiting for read data (rready)
    // WR    | write address/data offered, each drops on its own handshake
    // WR_B  | waiting for write response (bready)
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR   = 3'd3,
        WR_B = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        aw_ok;
    logic        w_ok;
    logic        misalign;
    logic [2:0]  ld_op_q;
    logic [1:0]  lane_q;
    logic [31:0] load_ext;
    logic [31:0] wdata_nx;
    logic [3:0]  wstrb_nx;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        rd_fin;
    logic        wr_fin;

    assign bus.arid = {ID_W{1'b0}};
    assign bus.awid = {ID_W{1'b0}};

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign = (op[1:0] == 2'b01 && addr[0]) ||
                      (op[1] && addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign rd_fin = (state == RD_D) && bus.rvalid;
    assign wr_fin = (state == WR_B) && bus.bvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (enable && !misalign) begin
                    state_nx = op[3] ? WR : RD_A;
                end
            end
            RD_A: if (bus.arready) state_nx = RD_D;
            RD_D: if (bus.rvalid)  state_nx = IDLE;
            WR: begin
                // Both channels may complete in the same cycle or in either order.
                if ((aw_ok || bus.awready) && (w_ok || bus.wready)) begin
                    state_nx = WR_B;
                end
            end
            WR_B: if (bus.bvalid)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.arvalid = (state == RD_A);
        bus.rready  = (state == RD_D);
        bus.awvalid = (state == WR) && !aw_ok;
        bus.wvalid  = (state == WR) && !w_ok;
        bus.bready  = (state == WR_B);
    end

    // Store lane replication and strobes, computed from the live request.
    always_comb begin
        wdata_nx = wd;
        wstrb_nx = 4'b1111;
        unique case (op[1:0])
            2'b00: begin
                wdata_nx = {4{wd[7:0]}};
                wstrb_nx = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_nx = {2{wd[15:0]}};
                wstrb_nx = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_nx = wd;
                wstrb_nx = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the size/sign/lane captured when the request was accepted.
    always_comb begin
        byte_sel = bus.rdata[{lane_q, 3'b000} +: 8];
        half_sel = bus.rdata[{lane_q[1], 4'b0000} +: 16];
        load_ext = bus.rdata;
        unique case (ld_op_q[1:0])
            2'b00:   load_ext = {{24{~ld_op_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{~ld_op_q[2] & half_sel[15]}}, half_sel};
            default: load_ext = bus.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done       <= 1'b0;
            err        <= 1'b0;
            data       <= 32'd0;
            bus.araddr <= '0;
            bus.awaddr <= '0;
            bus.wdata  <= 32'd0;
            bus.wstrb  <= 4'b0000;
            ld_op_q    <= 3'd0;
            lane_q     <= 2'd0;
            aw_ok      <= 1'b0;
            w_ok       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (state == IDLE) begin
                aw_ok <= 1'b0;
                w_ok  <= 1'b0;
                if (enable) begin
                    if (misalign) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end else begin
                        ld_op_q <= op[2:0];
                        lane_q  <= addr[1:0];
                        if (op[3]) begin
                            bus.awaddr <= {addr[ADDR_W-1:2], 2'b00};
                            bus.wdata  <= wdata_nx;
                            bus.wstrb  <= wstrb_nx;
                        end else begin
                            bus.araddr <= {addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
            end

            if (state == WR) begin
                if (bus.awready) aw_ok <= 1'b1;
                if (bus.wready)  w_ok  <= 1'b1;
            end

            // A read error still returns the data beat.
            if (rd_fin) begin
                done <= 1'b1;
                err  <= (bus.rresp != 2'b00);
                data <= load_ext;
            end

            if (wr_fin) begin
                done <= 1'b1;
                err  <= (bus.bresp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_lsu_exec.sv
// Randomized bench for lsu_exec: a bus responder with random delays and noise,
// checked against a byte-arithmetic model of load/store results and latencies.
module tb_lsu_exec;
    localparam int AW = 22;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [3:0]    op;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          done;
    logic [31:0]   data;
    logic          err;

    lsu_exec_if #(.ADDR_W(AW), .ID_W(4)) bus ();

    lsu_exec #(.ADDR_W(AW), .ID_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .op     (op),
        .addr   (addr),
        .wd     (wd),
        .done   (done),
        .data   (data),
        .err    (err),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] last_data = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic slave_idle();
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'd0;
        bus.rresp   = 2'b00;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
    endtask

    // busy: 0 enable low while busy, 1 random enable, 2 enable held high
    task automatic run_txn(input logic [3:0] t_op, input logic [AW-1:0] t_addr,
                           input logic [31:0] t_wd, input logic [31:0] t_rd,
                           input logic [1:0] t_resp, input int da, input int dw,
                           input int db, input int busy);
        int          nb, off, cyc, fin, ar_hs, r_hs, aw_hs, w_hs, b_hs;
        int          ca, cw, cb;
        bit          got, mis, is_st, traffic, ar_seen, aw_seen, w_seen;
        logic [31:0] mask, exp_data, exp_wdata;
        logic [3:0]  exp_strb;
        logic [AW-1:0] exp_word;

        is_st = t_op[3];
        case (t_op[1:0])
            2'b00:   begin nb = 1; off = int'(t_addr[1:0]);    end
            2'b01:   begin nb = 2; off = 2 * int'(t_addr[1]);  end
            default: begin nb = 4; off = 0;                    end
        endcase
        mask     = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
        exp_data = (t_rd >> (8 * off)) & mask;
        if (!t_op[2] && nb < 4 && exp_data[8 * nb - 1]) exp_data = exp_data | ~mask;
        exp_wdata = (nb == 1) ? t_wd[7:0] * 32'h0101_0101 :
                    (nb == 2) ? t_wd[15:0] * 32'h0001_0001 : t_wd;
        exp_strb  = 4'(((1 << nb) - 1) << off);
        exp_word  = (t_addr >> 2) << 2;
`ifdef LSU_ALIGN_CHECK_EN
        mis = (nb == 2 && t_addr[0]) || (nb == 4 && t_addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif

        ca = da; cw = dw; cb = db;
        cyc = 0; fin = 0; got = 0; traffic = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        ar_seen = 0; aw_seen = 0; w_seen = 0;

        @(negedge clk);
        enable = 1'b1; op = t_op; addr = t_addr; wd = t_wd;

        while (!got && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1;
                check("done_lat", cyc, mis ? 1 : fin + 1);
                if (da == 0 && dw == 0 && db == 0) check("min_lat", cyc, mis ? 1 : 3);
                check("err", err, (mis || t_resp != 2'b00) ? 1 : 0);
                if (!is_st && !mis) last_data = exp_data;
                check("data", data, last_data);
            end
            if (bus.arvalid || bus.awvalid) traffic = 1;
            if (got) begin
                enable = 1'b0;
                slave_idle();
            end else begin
                enable = (busy == 2) ? 1'b1 : (busy == 1) ? 1'($urandom % 2) : 1'b0;
                op   = 4'($urandom);
                addr = AW'($urandom);
                wd   = $urandom;

                if (bus.arvalid) begin
                    if (!ar_seen) check("araddr", 32'(bus.araddr), 32'(exp_word));
                    ar_seen = 1;
                    if (ca == 0) begin bus.arready = 1'b1; ar_hs++; end
                    else begin bus.arready = 1'b0; ca--; end
                end else bus.arready = 1'($urandom % 2);

                if (bus.rready) begin
                    if (cb == 0) begin
                        bus.rvalid = 1'b1; bus.rdata = t_rd; bus.rresp = t_resp;
                        r_hs++; fin = cyc;
                    end else begin
                        bus.rvalid = 1'b0; bus.rdata = $urandom; bus.rresp = 2'($urandom); cb--;
                    end
                end else if (!is_st) begin
                    bus.rvalid = 1'($urandom % 2); bus.rdata = $urandom; bus.rresp = 2'($urandom);
                end else begin
                    bus.rvalid = 1'b0;
                end

                if (bus.awvalid) begin
                    if (!aw_seen) check("awaddr", 32'(bus.awaddr), 32'(exp_word));
                    aw_seen = 1;
                    if (ca == 0) begin bus.awready = 1'b1; aw_hs++; end
                    else begin bus.awready = 1'b0; ca--; end
                end else bus.awready = 1'($urandom % 2);

                if (bus.wvalid) begin
                    if (!w_seen) begin
                        check("wdata", bus.wdata, exp_wdata);
                        check("wstrb", 32'(bus.wstrb), 32'(exp_strb));
                    end
                    w_seen = 1;
                    if (cw == 0) begin bus.wready = 1'b1; w_hs++; end
                    else begin bus.wready = 1'b0; cw--; end
                end else bus.wready = 1'($urandom % 2);

                if (bus.bready) begin
                    if (cb == 0) begin
                        bus.bvalid = 1'b1; bus.bresp = t_resp; b_hs++; fin = cyc;
                    end else begin
                        bus.bvalid = 1'b0; bus.bresp = 2'($urandom); cb--;
                    end
                end else if (is_st) begin
                    bus.bvalid = 1'($urandom % 2); bus.bresp = 2'($urandom);
                end else begin
                    bus.bvalid = 1'b0;
                end
            end
        end

        check("timeout", got, 1);
        check("traffic", traffic, mis ? 0 : 1);
        check("ar_hs", ar_hs, (!is_st && !mis) ? 1 : 0);
        check("r_hs",  r_hs,  (!is_st && !mis) ? 1 : 0);
        check("aw_hs", aw_hs, (is_st && !mis) ? 1 : 0);
        check("w_hs",  w_hs,  (is_st && !mis) ? 1 : 0);
        check("b_hs",  b_hs,  (is_st && !mis) ? 1 : 0);

        @(negedge clk);
        check("done_pulse", done, 0);
        check("idle_no_ar", bus.arvalid, 0);
        check("idle_no_aw", bus.awvalid, 0);
    endtask

    task automatic reset_mid_write();
        @(negedge clk);
        slave_idle();
        enable = 1'b1; op = 4'b1010; addr = AW'(22'h00_0010); wd = 32'h1234_5678;
        @(negedge clk);
        enable = 1'b0;
        check("rst_pre_awvalid", bus.awvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid",  bus.wvalid, 0);
        check("rst_rready",  bus.rready, 0);
        check("rst_bready",  bus.bready, 0);
        check("rst_done",    done, 0);
        check("rst_wstrb",   32'(bus.wstrb), 0);
        check("rst_wdata",   bus.wdata, 0);
        check("rst_awaddr",  32'(bus.awaddr), 0);
        check("rst_data",    data, 0);
        last_data = 32'd0;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
            check("rst_no_aw", bus.awvalid, 0);
        end
        slave_idle();
    endtask

    initial begin : main
        logic [3:0]  r_op;
        logic [1:0]  r_resp;

        rst = 1'b1; enable = 1'b0; op = 4'd0; addr = '0; wd = 32'd0;
        slave_idle();
        repeat (2) @(negedge clk);
        check("reset_done",    done, 0);
        check("reset_err",     err, 0);
        check("reset_data",    data, 0);
        check("reset_arvalid", bus.arvalid, 0);
        check("reset_awvalid", bus.awvalid, 0);
        check("reset_wvalid",  bus.wvalid, 0);
        check("reset_rready",  bus.rready, 0);
        check("reset_bready",  bus.bready, 0);
        check("reset_araddr",  32'(bus.araddr), 0);
        check("reset_wstrb",   32'(bus.wstrb), 0);
        check("arid_tie",      32'(bus.arid), 0);
        check("awid_tie",      32'(bus.awid), 0);
        rst = 1'b0;

        run_txn(4'b0000, AW'(22'h003), 32'd0, 32'h80FF_FF12, 2'b00, 0, 0, 0, 0);
        check("ex_signed_byte", data, 32'hFFFF_FF80);
        run_txn(4'b0101, AW'(22'h002), 32'd0, 32'hBEEF_1234, 2'b00, 0, 0, 0, 0);
        check("ex_unsigned_half", data, 32'h0000_BEEF);
        run_txn(4'b1000, AW'(22'h001), 32'h0000_00AB, 32'd0, 2'b00, 3, 0, 0, 0);
        run_txn(4'b0010, AW'(22'h000), 32'd0, 32'hCAFE_F00D, 2'b10, 0, 0, 2, 2);
        run_txn(4'b1011, AW'(22'h004), 32'h0BAD_BEEF, 32'd0, 2'b00, 0, 3, 1, 1);
        run_txn(4'b0010, AW'(22'h006), 32'd0, 32'h1357_9BDF, 2'b00, 0, 0, 0, 0);
        run_txn(4'b1001, AW'(22'h003), 32'h0000_5AA5, 32'd0, 2'b11, 1, 1, 1, 1);

        reset_mid_write();
        run_txn(4'b0001, AW'(22'h3F_FFFE), 32'd0, 32'h8001_7FFF, 2'b00, 1, 0, 1, 1);

        for (int i = 0; i < 150; i++) begin
            r_op   = 4'($urandom);
            r_resp = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(r_op, AW'($urandom), $urandom, $urandom, r_resp,
                    ($urandom % 3 == 0) ? 0 : $urandom_range(0, 3),
                    ($urandom % 3 == 0) ? 0 : $urandom_range(0, 3),
                    ($urandom % 3 == 0) ? 0 : $urandom_range(0, 3),
                    $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
